// File: rtl/morse_pkg.sv
// Shared definitions for the morse game blocks: phase encodings, code width
// and the 2-bit symbol alphabet packed into each code.
package morse_pkg;

    localparam int CODE_W = 10;

    typedef enum logic [1:0] {
        PH_RECORD = 2'b00,
        PH_GUESS  = 2'b01,
        PH_DONE   = 2'b10
    } phase_e;

    localparam logic [1:0] MORSE_NONE = 2'b00;
    localparam logic [1:0] MORSE_DOT  = 2'b01;
    localparam logic [1:0] MORSE_LINE = 2'b11;

    // Equality over a full code; code 0 (all MORSE_NONE) is a legal, empty code.
    function automatic logic codes_equal(input logic [CODE_W-1:0] a,
                                         input logic [CODE_W-1:0] b);
        return (a == b);
    endfunction

endpackage

// File: rtl/code_ram.sv
// Storage for player 1's code sequence: synchronous write, combinational read,
// so a code written at one edge is visible to the comparator the next cycle.
module code_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CODE_W = 10
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CODE_W-1:0] rd_data
);

    logic [CODE_W-1:0] mem_q [DEPTH];

    // Write port; contents are intentionally left uninitialised across resets.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/code_match.sv
// Two-player morse code game core: records player 1's sequence, scores player 2's
// guesses position by position, and reports win or loss once every code is answered.
module code_match
    import morse_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CODE_W = morse_pkg::CODE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p1_write,
    input  logic [CODE_W-1:0] p1_code,
    input  logic              p1_done,
    input  logic              p2_write,
    input  logic [CODE_W-1:0] p2_code,
    input  logic              restart,
    output logic [1:0]        phase,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   index,
    output logic              full,
    output logic              match,
    output logic              mismatch,
    output logic [ADDR_W:0]   score,
    output logic              win
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_C  = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    phase_e            phase_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   index_q;
    logic [ADDR_W:0]   score_q;
    logic              full_q;
    logic              match_q;
    logic              mismatch_q;
    logic              win_q;

    logic              p1_take_s;
    logic [ADDR_W:0]   count_d;
    logic [ADDR_W:0]   index_d;
    logic [ADDR_W:0]   score_d;
    logic              hit_s;
    logic [CODE_W-1:0] rd_data_s;

    code_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CODE_W (CODE_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (p1_take_s),
        .wr_addr (count_q[ADDR_W-1:0]),
        .wr_data (p1_code),
        .rd_addr (index_q[ADDR_W-1:0]),
        .rd_data (rd_data_s)
    );

    // Write acceptance and the incremented counters the FSM commits. count_d
    // already includes a same-cycle write so p1_done can close a one-code round.
    always_comb begin
        p1_take_s = (phase_q == PH_RECORD) && p1_write && (count_q != DEPTH_C);
        count_d   = p1_take_s ? (count_q + ONE_C) : count_q;
        hit_s     = codes_equal(p2_code, rd_data_s);
        index_d   = index_q + ONE_C;
        score_d   = hit_s ? (score_q + ONE_C) : score_q;
    end

    // Phase FSM with registered counters, result pulses and win flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q    <= PH_RECORD;
            count_q    <= ZERO_C;
            index_q    <= ZERO_C;
            score_q    <= ZERO_C;
            full_q     <= 1'b0;
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
            case (phase_q)
                PH_RECORD: begin
                    count_q <= count_d;
                    full_q  <= (count_d == DEPTH_C);
                    if (p1_done && (count_d != ZERO_C)) begin
                        phase_q <= PH_GUESS;
                        index_q <= ZERO_C;
                        score_q <= ZERO_C;
                    end
                end
                PH_GUESS: begin
                    if (p2_write) begin
                        match_q    <= hit_s;
                        mismatch_q <= !hit_s;
                        score_q    <= score_d;
                        index_q    <= index_d;
                        if (index_d == count_q) begin
                            phase_q <= PH_DONE;
                            win_q   <= (score_d == count_q);
                        end
                    end
                end
                PH_DONE: begin
                    if (restart) begin
                        phase_q <= PH_RECORD;
                        count_q <= ZERO_C;
                        index_q <= ZERO_C;
                        score_q <= ZERO_C;
                        full_q  <= 1'b0;
                        win_q   <= 1'b0;
                    end
                end
                default: begin
                    phase_q <= PH_RECORD;
                end
            endcase
        end
    end

    assign phase    = phase_q;
    assign count    = count_q;
    assign index    = index_q;
    assign score    = score_q;
    assign full     = full_q;
    assign match    = match_q;
    assign mismatch = mismatch_q;
    assign win      = win_q;

endmodule

// File: doc/code_match.md
# code_match

Downstream consumer of the per-player code builders. Player 1 records a sequence of 10-bit morse codes, each arriving with a one-cycle write strobe. Player 2 then enters codes in turn, and each is compared against the stored entry at the same position. The block tracks game phase, stores the sequence, scores matches and declares win or loss once player 2 has answered every stored code.

## Interface
- `DEPTH`, 16: maximum stored codes per round.
- `ADDR_W`, 4: address width; `DEPTH` equals 2**`ADDR_W`.
- `CODE_W`, 10: width of one code (five 2-bit morse symbols).

- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high; clears all state on the next edge.
- `p1_write` in 1: one-cycle strobe; `p1_code` is valid.
- `p1_code` in `CODE_W`: player 1 code.
- `p1_done` in 1: one-cycle strobe; player 1 has finished recording.
- `p2_write` in 1: one-cycle strobe; `p2_code` is valid.
- `p2_code` in `CODE_W`: player 2 code.
- `restart` in 1: one-cycle strobe; begins a new round (accepted in DONE only).
- `phase` out 2: RECORD=00, GUESS=01, DONE=10.
- `count` out `ADDR_W`+1: number of codes stored, 0..`DEPTH`.
- `index` out `ADDR_W`+1: number of player 2 guesses consumed.
- `full` out 1: `count`==`DEPTH`.
- `match` out 1: one-cycle pulse; the last guess equalled the stored code.
- `mismatch` out 1: one-cycle pulse; the last guess differed from the stored code.
- `score` out `ADDR_W`+1: matches so far this round.
- `win` out 1: high in DONE when `score`==`count`.

## Operation
- **Reset values:** `phase`=RECORD; `count`, `index`, `score`=0; `full`, `match`, `mismatch`, `win`=0. Memory contents are not cleared; they are don't-care.
- **RECORD:**
  - `p1_write` with `count`<`DEPTH`: write `p1_code` to mem[`count`], then `count`++.
  - `p1_write` while full: ignored. `count` stays at `DEPTH`.
  - `p1_done` with `count`>0: go to GUESS, `index`=0, `score`=0.
  - `p1_done` with `count`==0: ignored.
  - `p2_write` and `restart`: ignored.
- **p1_write and p1_done in the same cycle:** the write is stored first. The transition then uses the incremented count, so a one-code round is legal.
- **GUESS:**
  - `p2_write`: compare `p2_code` with mem[`index`[ADDR_W-1:0]] and pulse `match` or `mismatch`.
  - On `match`, `score`++.
  - `index`++ on every guess.
  - If `index`+1==`count`, go to DONE.
  - `p1_write` and `p1_done` are ignored.
- **DONE:**
  - `win` is registered at entry: `score` (including the final guess) == `count`.
  - `p2_write` and `p1_*` are ignored.
  - `restart`: go to RECORD and clear `count`, `index`, `score` and `win`.
- **Code values:** all 10-bit values are legal, including 0, which is an empty code. Compare is a full 10-bit equality.
- **Priority:** `reset` > `restart` > phase-specific strobes.

## Timing
- All outputs are registered.
- Strobe sampled at edge N:
  - `count`, `index`, `score` and `phase` update at N.
  - `match`/`mismatch` are high for exactly the cycle following edge N.
- Back-to-back strobes on consecutive cycles are accepted at full rate; there is no back-pressure.
- Memory read is combinational (asynchronous) off `index`. A write at edge N is readable from cycle N+1.
- Reset mid-round returns to RECORD in one edge and drops any pulse in flight.

## Structure
- Shared package `morse_pkg`:
  - phase encodings `PH_RECORD`, `PH_GUESS`, `PH_DONE`;
  - `CODE_W`;
  - symbol constants `MORSE_NONE`=00, `MORSE_DOT`=01, `MORSE_LINE`=11.
- Sub-module `code_ram`: `DEPTH`×`CODE_W` register array, synchronous write, asynchronous read.
- The top level holds the phase FSM, counters and compare.

## Test plan
- **Record and match all:** store 0x001, 0x00D, 0x3FF; `p1_done`; guess the same three codes. Expect `match` ×3, `score`=3, `phase`=DONE, `win`=1.
- **One mismatch:** store 0x005, 0x007; guess 0x005, 0x006. Expect `match` then `mismatch`, `score`=1, DONE, `win`=0.
- **Overflow:** 17 writes. Expect `count`=16 and `full`=1, with mem[15] holding the 16th code. Then `p1_done`, and 16 correct guesses give `win`=1.
- **Same-cycle and empty done:** `p1_done` at `count`=0 stays in RECORD. `p1_write`(0x00C) together with `p1_done` gives `count`=1 and GUESS. One guess of 0x00C gives DONE and `win`=1.
- **Ignored strobes:** `p2_write` in RECORD and `p1_write` in GUESS leave all counters unchanged. `restart` in GUESS is ignored.
- **Reset mid-GUESS:** after 2 of 4 guesses, assert `reset`. Expect `phase`=RECORD, all counters 0, no pulse. Then `restart` from DONE in a later round clears `win`.
